// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch-queue bus signals between imem, EX redirect
// and the decode stage.
//   slave  modport: used by fetch_queue (drives PCF, ValidD, InstrD, PCD, Count)
//   master modport: used by the surrounding pipeline/testbench (drives InstrF,
//                   ImemValidF, RedirectE, PCTargetE, ReadyD)
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] PCF;
    logic [31:0]     InstrF;
    logic            ImemValidF;
    logic            RedirectE;
    logic [XLEN-1:0] PCTargetE;
    logic            ValidD;
    logic            ReadyD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [CW-1:0]   Count;

    modport slave (
        output PCF, ValidD, InstrD, PCD, Count,
        input  InstrF, ImemValidF, RedirectE, PCTargetE, ReadyD
    );

    modport master (
        input  PCF, ValidD, InstrD, PCD, Count,
        output InstrF, ImemValidF, RedirectE, PCTargetE, ReadyD
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between imem and decode.
// Owns the fetch PC and prefetches up to DEPTH {PC, instr} pairs so that imem
// wait states and decode stalls are decoupled. A redirect from EX flushes the
// queue and restarts fetch at the target.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - fetch_queue_if.slave: PCF/InstrF/ImemValidF (imem side),
//          RedirectE/PCTargetE (EX side), ValidD/ReadyD/InstrD/PCD (decode
//          side), Count (occupancy)
// Build option:
//   FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards InstrF/PCF
//   straight to decode in the same cycle (0-cycle latency).
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Entry layout: {pc, instr}
    logic [XLEN+31:0] mem [DEPTH];

    logic [XLEN-1:0] pcf;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic full, empty;
    logic valid_d, pop, push, pc_adv;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp, byp_take;

    // Empty queue with a live imem word: present it to decode directly.
    assign byp      = empty & bus.ImemValidF & ~bus.RedirectE;
    // Decode takes the bypassed word, so it is never written into the queue.
    assign byp_take = byp & bus.ReadyD;

    assign valid_d    = (~empty | byp) & ~bus.RedirectE;
    assign pop        = ~empty & valid_d & bus.ReadyD;
    assign push       = bus.ImemValidF & ~bus.RedirectE & (~full | pop) & ~byp_take;
    assign pc_adv     = push | byp_take;
    assign head_pc    = byp ? pcf        : mem[rd_ptr][XLEN+31:32];
    assign head_instr = byp ? bus.InstrF : mem[rd_ptr][31:0];
`else
    assign valid_d    = ~empty & ~bus.RedirectE;
    assign pop        = valid_d & bus.ReadyD;
    // A full queue can still accept when the head leaves in the same cycle.
    assign push       = bus.ImemValidF & ~bus.RedirectE & (~full | pop);
    assign pc_adv     = push;
    assign head_pc    = mem[rd_ptr][XLEN+31:32];
    assign head_instr = mem[rd_ptr][31:0];
`endif

    // Storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pcf, bus.InstrF};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.RedirectE) begin
            // Redirect overrides any push/pop this cycle.
            pcf    <= bus.PCTargetE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pc_adv)
                pcf <= pcf + XLEN'(4);
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are gated so nothing stale (or unwritten) leaks to decode.
    always_comb begin
        bus.ValidD = valid_d;
        bus.InstrD = NOP;
        bus.PCD    = '0;
        if (valid_d) begin
            bus.InstrD = head_instr;
            bus.PCD    = head_pc;
        end
    end

    assign bus.PCF   = pcf;
    assign bus.Count = count;
endmodule
